popcount_frame_acc: RTL and testbench
=====================================

Name: popcount_frame_acc

Overview:
- Downstream consumer of the per-word popcount stage.
- Takes one registered ones-count per data word and accumulates the counts over a frame delimited by in_last.
- Presents a per-frame summary through a valid/ready handshake: total ones, word count, per-word maximum, threshold flag and saturation flag.
- Feeds frame-level statistics and alarm logic.

Parameters:
- CNT_WIDTH, 6, width of the per-word count input; holds 0..32 for a 32-bit word.
- SUM_WIDTH, 16, width of the frame ones accumulator and of threshold.
- WCNT_WIDTH, 8, width of the frame word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_count/in_last valid.
- in_ready  out  1  block accepts an input word this cycle.
- in_count  in  CNT_WIDTH  ones count of one word.
- in_last  in  1  word is the final word of its frame.
- threshold  in  SUM_WIDTH  alarm level, sampled on the last-word transfer.
- out_valid  out  1  frame summary valid.
- out_ready  in  1  consumer accepts the summary.
- out_sum  out  SUM_WIDTH  total ones in the frame, saturating.
- out_words  out  WCNT_WIDTH  words in the frame, saturating.
- out_max  out  CNT_WIDTH  largest in_count in the frame.
- out_over  out  1  out_sum >= threshold.
- out_sat  out  1  out_sum or out_words saturated during the frame.

Behaviour:
- Reset (async assert, sync-safe release):
  - acc_sum, acc_words, acc_max, acc_sat = 0.
  - All out_* registers = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- in_ready = !out_valid | out_ready (combinational). Summary backpressure stalls input; there is no other input stall.
- Two-state control:
  - ACC (out_valid = 0).
  - HOLD (out_valid = 1).
- Non-last input transfer:
  - acc_sum = min(acc_sum + in_count, 2^SUM_WIDTH-1).
  - acc_words = min(acc_words + 1, 2^WCNT_WIDTH-1).
  - acc_max = max(acc_max, in_count).
  - acc_sat is set if either saturation occurs; it stays set until frame end.
- Last input transfer:
  - Compute the same next values including this word.
  - Load them into out_sum, out_words, out_max, out_sat.
  - out_over = (next sum >= threshold of this cycle).
  - out_valid = 1 next cycle; clear all acc_* to 0 the same edge.
  - Latency: out_valid rises 1 cycle after the last-word transfer.
- HOLD:
  - out_* are stable until the output transfer.
  - On output transfer with no new last-word transfer: out_valid = 0 next cycle (→ ACC).
- Simultaneous output transfer and input transfer in HOLD (allowed because out_ready = 1):
  - Input is accumulated normally.
  - If it is also in_last, out_* reload with the new frame and out_valid stays 1. This allows back-to-back single-word frames at full rate.
- Single-word frame (first word carries in_last):
  - out_words = 1, out_sum = out_max = in_count.
- A frame with in_count = 0 on every word gives out_sum = 0; out_over = 1 only if threshold = 0.
- in_valid while in_ready = 0: no state change; the upstream stage holds its data.
- Reset mid-frame or mid-HOLD: the partial frame and any pending summary are discarded; there is no output for them.
- All arithmetic is unsigned.
  - Comparisons use full width before saturation clamp, with one extra carry bit.
  - No wrap-around is permitted.

Test Plan:
- Reset then frame counts 3,7,0,5(last), threshold=15, out_ready=1 -> one cycle after last: out_valid=1, out_sum=15, out_words=4, out_max=7, out_over=1, out_sat=0.
- Same frame with threshold=16 -> out_over=0; then out_ready=0 for 5 cycles -> out_* stable, in_ready=0, offered next word not consumed until out_ready=1.
- Back-to-back single-word frames 9(last), 2(last), 32(last) with out_ready=1 every cycle -> out_valid held high 3 consecutive cycles with out_sum 9, 2, 32; in_ready never drops.
- SUM_WIDTH=6, counts 32,32(last) -> out_sum=63, out_sat=1; next frame 1(last) -> out_sum=1, out_sat=0 (flag cleared per frame).
- 300 words of count 1, last on 300th -> out_words=255, out_sat=1, out_sum=300.
- Assert rst after 3 words of a frame, release, send 4(last) -> out_sum=4, out_words=1; rst asserted during HOLD -> out_valid falls asynchronously, no summary delivered.

Source files
------------

// File: rtl/popcount_frame_acc_if.sv
// Word-count stream in, frame-summary stream out, for the popcount frame accumulator.
// slave is the accumulator side; master is the upstream producer / downstream consumer side.
interface popcount_frame_acc_if #(
  parameter int CNT_WIDTH  = 6,
  parameter int SUM_WIDTH  = 16,
  parameter int WCNT_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CNT_WIDTH-1:0]  in_count;
  logic                  in_last;
  logic [SUM_WIDTH-1:0]  threshold;

  logic                  out_valid;
  logic                  out_ready;
  logic [SUM_WIDTH-1:0]  out_sum;
  logic [WCNT_WIDTH-1:0] out_words;
  logic [CNT_WIDTH-1:0]  out_max;
  logic                  out_over;
  logic                  out_sat;

  modport slave (
    input  in_valid, in_count, in_last, threshold, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_max, out_over, out_sat
  );

  modport master (
    output in_valid, in_count, in_last, threshold, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_max, out_over, out_sat
  );
endinterface

// File: rtl/popcount_frame_acc.sv
// Accumulates per-word ones counts over an in_last-delimited frame and presents a
// saturating frame summary (sum, words, max, threshold and saturation flags).
//   state | meaning
//   ACC   | accumulating a frame, no summary pending
//   HOLD  | summary presented on out_*, waiting for out_ready
module popcount_frame_acc #(
  parameter int CNT_WIDTH  = 6,
  parameter int SUM_WIDTH  = 16,
  parameter int WCNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_frame_acc_if.slave  bus
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SUM_WIDTH-1:0]  acc_sum;
  logic [WCNT_WIDTH-1:0] acc_words;
  logic [CNT_WIDTH-1:0]  acc_max;
  logic                  acc_sat;

  logic [SUM_WIDTH-1:0]  out_sum;
  logic [WCNT_WIDTH-1:0] out_words;
  logic [CNT_WIDTH-1:0]  out_max;
  logic                  out_over;
  logic                  out_sat;

  logic                  out_valid;
  logic                  in_ready;
  logic                  in_fire;
  logic                  last_fire;

  logic [SUM_WIDTH:0]    sum_ext;
  logic [WCNT_WIDTH:0]   words_ext;
  logic [SUM_WIDTH-1:0]  sum_nxt;
  logic [WCNT_WIDTH-1:0] words_nxt;
  logic [CNT_WIDTH-1:0]  max_nxt;
  logic                  sat_nxt;
  logic                  over_nxt;

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid || bus.out_ready;
  assign in_fire   = bus.in_valid && in_ready;
  assign last_fire = in_fire && bus.in_last;

  // One carry bit above each accumulator catches overflow before the clamp.
  always_comb begin
    sum_ext   = {1'b0, acc_sum} + {{(SUM_WIDTH + 1 - CNT_WIDTH){1'b0}}, bus.in_count};
    words_ext = {1'b0, acc_words} + {{WCNT_WIDTH{1'b0}}, 1'b1};
    sum_nxt   = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
    words_nxt = words_ext[WCNT_WIDTH] ? {WCNT_WIDTH{1'b1}} : words_ext[WCNT_WIDTH-1:0];
    max_nxt   = (bus.in_count > acc_max) ? bus.in_count : acc_max;
    sat_nxt   = acc_sat || sum_ext[SUM_WIDTH] || words_ext[WCNT_WIDTH];
    over_nxt  = (sum_ext >= {1'b0, bus.threshold});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC: begin
        if (last_fire) state_nxt = HOLD;
      end
      HOLD: begin
        if (!last_fire && bus.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum   <= '0;
      acc_words <= '0;
      acc_max   <= '0;
      acc_sat   <= 1'b0;
    end else if (in_fire) begin
      if (bus.in_last) begin
        acc_sum   <= '0;
        acc_words <= '0;
        acc_max   <= '0;
        acc_sat   <= 1'b0;
      end else begin
        acc_sum   <= sum_nxt;
        acc_words <= words_nxt;
        acc_max   <= max_nxt;
        acc_sat   <= sat_nxt;
      end
    end
  end

  // The summary only changes on a last-word transfer, so it is stable throughout HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_words <= '0;
      out_max   <= '0;
      out_over  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (last_fire) begin
      out_sum   <= sum_nxt;
      out_words <= words_nxt;
      out_max   <= max_nxt;
      out_over  <= over_nxt;
      out_sat   <= sat_nxt;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_words = out_words;
  assign bus.out_max   = out_max;
  assign bus.out_over  = out_over;
  assign bus.out_sat   = out_sat;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Directed bench for popcount_frame_acc: default instance plus a SUM_WIDTH=6 instance
// for sum saturation.
module tb_popcount_frame_acc;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  popcount_frame_acc_if #(.CNT_WIDTH(6), .SUM_WIDTH(16), .WCNT_WIDTH(8)) bus ();
  popcount_frame_acc_if #(.CNT_WIDTH(6), .SUM_WIDTH(6),  .WCNT_WIDTH(8)) sbus ();

  popcount_frame_acc #(.CNT_WIDTH(6), .SUM_WIDTH(16), .WCNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  popcount_frame_acc #(.CNT_WIDTH(6), .SUM_WIDTH(6), .WCNT_WIDTH(8)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one word on the main instance and return at the following falling edge.
  task automatic word(input logic [5:0] c, input logic l);
    bus.in_valid = 1'b1;
    bus.in_count = c;
    bus.in_last  = l;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_count   = '0;
    bus.in_last    = 1'b0;
    bus.threshold  = '0;
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.in_count  = '0;
    sbus.in_last   = 1'b0;
    sbus.threshold = '0;
    sbus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum",   bus.out_sum,   0);
    chk("rst_out_words", bus.out_words, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    rst = 1'b0;

    // frame 3,7,0,5 threshold 15
    bus.threshold = 15;
    word(3, 0); word(7, 0); word(0, 0); word(5, 1);
    bus.in_valid = 1'b0;
    chk("f1_valid", bus.out_valid, 1);
    chk("f1_sum",   bus.out_sum,   15);
    chk("f1_words", bus.out_words, 4);
    chk("f1_max",   bus.out_max,   7);
    chk("f1_over",  bus.out_over,  1);
    chk("f1_sat",   bus.out_sat,   0);
    @(negedge clk);
    chk("f1_drain", bus.out_valid, 0);

    // same frame, threshold 16, then backpressure with a word on offer
    bus.threshold = 16;
    bus.out_ready = 1'b0;
    word(3, 0); word(7, 0); word(0, 0); word(5, 1);
    bus.in_count = 6;
    bus.in_last  = 1'b0;
    chk("f2_over",     bus.out_over, 0);
    chk("f2_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_sum",   bus.out_sum,   15);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_ready", bus.in_ready,  0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", bus.out_valid, 0);
    word(1, 1);
    chk("f3_sum",   bus.out_sum,   7);
    chk("f3_words", bus.out_words, 2);
    chk("f3_max",   bus.out_max,   6);

    // back-to-back single-word frames
    word(9, 1);
    chk("b2b0_valid", bus.out_valid, 1);
    chk("b2b0_sum",   bus.out_sum,   9);
    chk("b2b0_words", bus.out_words, 1);
    chk("b2b0_max",   bus.out_max,   9);
    chk("b2b0_ready", bus.in_ready,  1);
    word(2, 1);
    chk("b2b1_valid", bus.out_valid, 1);
    chk("b2b1_sum",   bus.out_sum,   2);
    chk("b2b1_ready", bus.in_ready,  1);
    word(32, 1);
    chk("b2b2_valid", bus.out_valid, 1);
    chk("b2b2_sum",   bus.out_sum,   32);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", bus.out_valid, 0);

    // all-zero frames against threshold 0 and 1
    bus.threshold = 0;
    word(0, 0); word(0, 1);
    bus.in_valid = 1'b0;
    chk("zero_sum",   bus.out_sum,  0);
    chk("zero_over0", bus.out_over, 1);
    @(negedge clk);
    bus.threshold = 1;
    word(0, 1);
    bus.in_valid = 1'b0;
    chk("zero_over1", bus.out_over, 0);
    @(negedge clk);

    // 6-bit sum saturation, then flag cleared on the next frame
    sbus.threshold = 63;
    sbus.in_valid  = 1'b1;
    sbus.in_count  = 32;
    sbus.in_last   = 1'b0;
    @(negedge clk);
    sbus.in_last   = 1'b1;
    @(negedge clk);
    sbus.in_valid  = 1'b0;
    chk("ssat_sum",   sbus.out_sum,   63);
    chk("ssat_sat",   sbus.out_sat,   1);
    chk("ssat_words", sbus.out_words, 2);
    chk("ssat_over",  sbus.out_over,  1);
    @(negedge clk);
    sbus.in_valid  = 1'b1;
    sbus.in_count  = 1;
    sbus.in_last   = 1'b1;
    @(negedge clk);
    sbus.in_valid  = 1'b0;
    chk("snext_sum",  sbus.out_sum,  1);
    chk("snext_sat",  sbus.out_sat,  0);
    chk("snext_over", sbus.out_over, 0);

    // 300 words of one: word counter saturates, sum does not
    bus.threshold = 300;
    for (int i = 0; i < 299; i++) word(1, 0);
    word(1, 1);
    bus.in_valid = 1'b0;
    chk("w300_words", bus.out_words, 255);
    chk("w300_sat",   bus.out_sat,   1);
    chk("w300_sum",   bus.out_sum,   300);
    chk("w300_max",   bus.out_max,   1);
    chk("w300_over",  bus.out_over,  1);
    @(negedge clk);

    // reset mid-frame discards the partial frame
    word(5, 0); word(5, 0); word(5, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    word(4, 1);
    bus.in_valid = 1'b0;
    chk("rmid_sum",   bus.out_sum,   4);
    chk("rmid_words", bus.out_words, 1);
    chk("rmid_max",   bus.out_max,   4);
    @(negedge clk);

    // reset during HOLD drops the pending summary asynchronously
    bus.out_ready = 1'b0;
    word(8, 1);
    bus.in_valid = 1'b0;
    chk("rhold_pre", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rhold_valid", bus.out_valid, 0);
    chk("rhold_sum",   bus.out_sum,   0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rhold_none",  bus.out_valid, 0);
    end
    chk("rhold_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
